// File: rtl/mips_pkg.sv
`default_nettype none
// ============================================================================
// Package  : mips_pkg
// Brief    : Shared encodings for the multi-cycle MIPS sequencer: opcodes,
//            ALU operation / operand-B / PC-source mux codes and the sequencer
//            state enum.
// Config   : MULTICYCLE_CONTROL_ADDI_EN adds the ADDIEX/ADDIWB states and
//            makes opcode 001000 a supported instruction.
// Revision : 1.0 - initial release
// ============================================================================
package mips_pkg;

    // Primary opcode field instr[31:26]
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    // ALU operation select
    localparam logic [1:0] ALUOP_FUNCT = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_ADD   = 2'b11;

    // ALU operand B select
    localparam logic [1:0] ALUSRCB_RT    = 2'b00;
    localparam logic [1:0] ALUSRCB_FOUR  = 2'b01;
    localparam logic [1:0] ALUSRCB_IMM   = 2'b10;
    localparam logic [1:0] ALUSRCB_IMMSH = 2'b11;

    // PC source select
    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

`ifdef MULTICYCLE_CONTROL_ADDI_EN
    localparam bit ADDI_ENABLED = 1'b1;
`else
    localparam bit ADDI_ENABLED = 1'b0;
`endif

    // Sequencer states; the addi pair only exists when the feature is built in
    typedef enum logic [3:0] {
        FETCH   = 4'd0,
        DECODE  = 4'd1,
        MEMADR  = 4'd2,
        MEMRD   = 4'd3,
        MEMWB   = 4'd4,
        MEMWR   = 4'd5,
        RTYPEEX = 4'd6,
        RTYPEWB = 4'd7,
        BEQEX   = 4'd8,
        JEX     = 4'd9
`ifdef MULTICYCLE_CONTROL_ADDI_EN
        ,
        ADDIEX  = 4'd10,
        ADDIWB  = 4'd11
`endif
    } mc_state_t;

    // True when DECODE has somewhere to dispatch this opcode
    function automatic logic isLegalOp(input logic [5:0] op);
        return (op == OP_LW) || (op == OP_SW) || (op == OP_RTYPE) ||
               (op == OP_BEQ) || (op == OP_J) ||
               (ADDI_ENABLED && (op == OP_ADDI));
    endfunction

endpackage
`default_nettype wire

// File: rtl/multicycle_control_outdec.sv
`default_nettype none
// ============================================================================
// Module   : multicycle_control_outdec
// Brief    : Combinational control-output decode for the multi-cycle MIPS
//            sequencer. Moore decode of the state, plus the few outputs that
//            also look at memReady, zero or opcode in the same cycle.
// Config   : MULTICYCLE_CONTROL_ADDI_EN enables decode of ADDIEX/ADDIWB.
// Revision : 1.0 - initial release
// ============================================================================
module multicycle_control_outdec
    import mips_pkg::*;
(
    input  mc_state_t   state,
    input  logic        memReady,
    input  logic        zero,
    input  logic [5:0]  opcode,
    output logic        memRead,
    output logic        memWrite,
    output logic        iOrD,
    output logic        irWrite,
    output logic        pcEn,
    output logic [1:0]  pcSrc,
    output logic        regDst,
    output logic        memToReg,
    output logic        regWrite,
    output logic        aluSrcA,
    output logic [1:0]  aluSrcB,
    output logic [1:0]  aluOp,
    output logic        instrDone,
    output logic        illegalOp
);

    logic w_pcWrite;
    logic w_branch;

    // Per-state control decode; everything not named for a state stays 0
    always_comb begin
        memRead   = 1'b0;
        memWrite  = 1'b0;
        iOrD      = 1'b0;
        irWrite   = 1'b0;
        pcSrc     = PCSRC_ALU;
        regDst    = 1'b0;
        memToReg  = 1'b0;
        regWrite  = 1'b0;
        aluSrcA   = 1'b0;
        aluSrcB   = ALUSRCB_RT;
        aluOp     = ALUOP_FUNCT;
        instrDone = 1'b0;
        illegalOp = 1'b0;
        w_pcWrite = 1'b0;
        w_branch  = 1'b0;
        case (state)
            FETCH: begin
                // PC+4 computed in parallel with the instruction read
                memRead   = 1'b1;
                aluSrcB   = ALUSRCB_FOUR;
                aluOp     = ALUOP_ADD;
                pcSrc     = PCSRC_ALU;
                irWrite   = memReady;
                w_pcWrite = memReady;
            end
            DECODE: begin
                // Branch target precomputed into ALUOut while decoding
                aluSrcB   = ALUSRCB_IMMSH;
                aluOp     = ALUOP_ADD;
                illegalOp = !isLegalOp(opcode);
                instrDone = !isLegalOp(opcode);
            end
            MEMADR: begin
                aluSrcA = 1'b1;
                aluSrcB = ALUSRCB_IMM;
                aluOp   = ALUOP_ADD;
            end
            MEMRD: begin
                iOrD    = 1'b1;
                memRead = 1'b1;
            end
            MEMWB: begin
                regWrite  = 1'b1;
                memToReg  = 1'b1;
                instrDone = 1'b1;
            end
            MEMWR: begin
                iOrD      = 1'b1;
                memWrite  = 1'b1;
                instrDone = memReady;
            end
            RTYPEEX: begin
                aluSrcA = 1'b1;
                aluSrcB = ALUSRCB_RT;
                aluOp   = ALUOP_FUNCT;
            end
            RTYPEWB: begin
                regWrite  = 1'b1;
                regDst    = 1'b1;
                instrDone = 1'b1;
            end
            BEQEX: begin
                aluSrcA   = 1'b1;
                aluSrcB   = ALUSRCB_RT;
                aluOp     = ALUOP_SUB;
                w_branch  = 1'b1;
                pcSrc     = PCSRC_ALUOUT;
                instrDone = 1'b1;
            end
            JEX: begin
                pcSrc     = PCSRC_JUMP;
                w_pcWrite = 1'b1;
                instrDone = 1'b1;
            end
`ifdef MULTICYCLE_CONTROL_ADDI_EN
            ADDIEX: begin
                aluSrcA = 1'b1;
                aluSrcB = ALUSRCB_IMM;
                aluOp   = ALUOP_ADD;
            end
            ADDIWB: begin
                regWrite  = 1'b1;
                instrDone = 1'b1;
            end
`endif
            default: begin
            end
        endcase
    end

    // Conditional branch resolves from the live zero flag
    assign pcEn = w_pcWrite | (w_branch & zero);

endmodule
`default_nettype wire

// File: rtl/multicycle_control.sv
`default_nettype none
// ============================================================================
// Module   : multicycle_control
// Brief    : Multi-cycle MIPS control sequencer. Holds the state register and
//            next-state logic, delegates output decode to the outdec
//            sub-module and forces every output low while reset is high.
// Config   : MULTICYCLE_CONTROL_ADDI_EN - when defined, opcode 001000 runs
//            as addi (ADDIEX/ADDIWB); otherwise it is reported as illegal.
// Revision : 1.0 - initial release
// ============================================================================
module multicycle_control
    import mips_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic [5:0]  opcode,
    input  logic        zero,
    input  logic        memReady,
    output logic        memRead,
    output logic        memWrite,
    output logic        iOrD,
    output logic        irWrite,
    output logic        pcEn,
    output logic [1:0]  pcSrc,
    output logic        regDst,
    output logic        memToReg,
    output logic        regWrite,
    output logic        aluSrcA,
    output logic [1:0]  aluSrcB,
    output logic [1:0]  aluOp,
    output logic        instrDone,
    output logic        illegalOp
);

    mc_state_t   r_state;
    mc_state_t   w_nextState;

    logic        w_memRead;
    logic        w_memWrite;
    logic        w_iOrD;
    logic        w_irWrite;
    logic        w_pcEn;
    logic [1:0]  w_pcSrc;
    logic        w_regDst;
    logic        w_memToReg;
    logic        w_regWrite;
    logic        w_aluSrcA;
    logic [1:0]  w_aluSrcB;
    logic [1:0]  w_aluOp;
    logic        w_instrDone;
    logic        w_illegalOp;

    // State register; reset abandons any instruction and restarts at FETCH
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= FETCH;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Next-state: memory states hold until memReady, opcode steers dispatch
    always_comb begin
        w_nextState = r_state;
        case (r_state)
            FETCH:   if (memReady) w_nextState = DECODE;
            DECODE: begin
                case (opcode)
                    OP_LW, OP_SW: w_nextState = MEMADR;
                    OP_RTYPE:     w_nextState = RTYPEEX;
                    OP_BEQ:       w_nextState = BEQEX;
`ifdef MULTICYCLE_CONTROL_ADDI_EN
                    OP_ADDI:      w_nextState = ADDIEX;
`endif
                    OP_J:         w_nextState = JEX;
                    default:      w_nextState = FETCH;
                endcase
            end
            MEMADR:  w_nextState = (opcode == OP_LW) ? MEMRD : MEMWR;
            MEMRD:   if (memReady) w_nextState = MEMWB;
            MEMWB:   w_nextState = FETCH;
            MEMWR:   if (memReady) w_nextState = FETCH;
            RTYPEEX: w_nextState = RTYPEWB;
            RTYPEWB: w_nextState = FETCH;
            BEQEX:   w_nextState = FETCH;
            JEX:     w_nextState = FETCH;
`ifdef MULTICYCLE_CONTROL_ADDI_EN
            ADDIEX:  w_nextState = ADDIWB;
            ADDIWB:  w_nextState = FETCH;
`endif
            default: w_nextState = FETCH;
        endcase
    end

    multicycle_control_outdec u_outdec (
        .state     (r_state),
        .memReady  (memReady),
        .zero      (zero),
        .opcode    (opcode),
        .memRead   (w_memRead),
        .memWrite  (w_memWrite),
        .iOrD      (w_iOrD),
        .irWrite   (w_irWrite),
        .pcEn      (w_pcEn),
        .pcSrc     (w_pcSrc),
        .regDst    (w_regDst),
        .memToReg  (w_memToReg),
        .regWrite  (w_regWrite),
        .aluSrcA   (w_aluSrcA),
        .aluSrcB   (w_aluSrcB),
        .aluOp     (w_aluOp),
        .instrDone (w_instrDone),
        .illegalOp (w_illegalOp)
    );

    // Reset gates every output low in the same cycle, so no write strobe
    // can escape while the state register is being reloaded
    assign memRead   = w_memRead   & ~reset;
    assign memWrite  = w_memWrite  & ~reset;
    assign iOrD      = w_iOrD      & ~reset;
    assign irWrite   = w_irWrite   & ~reset;
    assign pcEn      = w_pcEn      & ~reset;
    assign pcSrc     = reset ? 2'b00 : w_pcSrc;
    assign regDst    = w_regDst    & ~reset;
    assign memToReg  = w_memToReg  & ~reset;
    assign regWrite  = w_regWrite  & ~reset;
    assign aluSrcA   = w_aluSrcA   & ~reset;
    assign aluSrcB   = reset ? 2'b00 : w_aluSrcB;
    assign aluOp     = reset ? 2'b00 : w_aluOp;
    assign instrDone = w_instrDone & ~reset;
    assign illegalOp = w_illegalOp & ~reset;

endmodule
`default_nettype wire
